exec_stat_counter: RTL
======================

Name: exec_stat_counter

Overview:
- Execution-statistics unit for the single-cycle MIPS CPU.
- Counts four quantities while the CPU runs: total executed cycles, unconditional jumps, conditional branches, and taken conditional branches.
- Freezes all counts when the CPU halts on a syscall.
- Sits directly upstream of the display-select mux, which consumes its four 16-bit count outputs.

Parameters:
- CNT_W, 16, width of each counter. The display mux expects 16.
- SATURATE, 1. When 1, counters stick at all-ones. When 0, counters wrap to 0.

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high reset
- ce  input  1  instruction-retire enable. One instruction completes on each clk edge where ce=1.
- halt  input  1  syscall-halt decode of the current instruction
- go  input  1  resume request. Only meaningful in HALTED.
- is_jump  input  1  current instruction is j/jal/jr
- is_branch  input  1  current instruction is a conditional branch (beq/bne/etc.)
- branch_taken  input  1  branch condition true for the current instruction
- all_time  output  CNT_W  executed-instruction count
- j_change  output  CNT_W  unconditional jump count
- b_change  output  CNT_W  conditional branch count
- b_change_success  output  CNT_W  taken conditional branch count
- halted  output  1  1 while in HALTED
- ovf  output  1  sticky flag. Set when any counter reaches all-ones and an increment is requested.

Behaviour:
- Reset:
  - Evaluated only on the rising clk edge with reset=1.
  - All counters = 0, ovf = 0, halted = 0, state = RUN.
  - Reset overrides every other input, including mid-run and while HALTED.
- States: RUN, HALTED.
  - RUN with ce=1:
    - all_time increments.
    - j_change increments if is_jump.
    - b_change increments if is_branch.
    - b_change_success increments if is_branch AND branch_taken.
    - branch_taken without is_branch is ignored.
    - Increments are independent. Any combination may occur in the same cycle, each counter adding at most 1.
  - RUN with ce=0: no counter changes; halt and go are ignored.
  - RUN, ce=1, halt=1:
    - The halting instruction itself is counted, including any jump/branch flags asserted with it.
    - Next state is HALTED; halted=1 from the following cycle.
  - HALTED:
    - No counter changes regardless of ce, is_jump, is_branch or branch_taken.
    - go=1 sampled on an edge moves to RUN at that edge.
    - The first counted instruction is on the next ce=1 edge after that.
    - ce is not required for the HALTED-to-RUN transition.
  - RUN, go=1: no effect.
- Latency:
  - Outputs are registered and reflect the instruction retired at the previous edge.
  - No combinational path from any input to any output.
- Saturation:
  - SATURATE=1: a counter at all-ones stays at all-ones. Each counter saturates independently.
  - SATURATE=0: the counter wraps to 0.
  - In either mode, ovf is set on the first increment request to a counter already at all-ones. It stays set until reset.
- Invariant: b_change_success <= b_change <= all_time and j_change <= all_time, as long as no counter has saturated or wrapped.
- Arithmetic: unsigned CNT_W-bit, with no carry between counters.

Test Plan:
- Reset then idle: reset=1 for 1 edge, then ce=0 for 10 edges -> all counters 0, halted=0, ovf=0.
- Mixed stream: ce=1 for 8 edges carrying 2 jumps, 3 branches (2 taken), 1 branch_taken with is_branch=0, and 2 plain instructions -> all_time=8, j_change=2, b_change=3, b_change_success=2.
- Halt freeze: 5 instructions, then halt=1 together with is_branch=1 and branch_taken=1 on the 6th, then 10 edges of ce=1 with is_jump=1 -> all_time=6, b_change=1, b_change_success=1, j_change=0, halted=1. Then go=1 for one edge, then 3 plain instructions -> all_time=9, halted=0.
- Saturation: SATURATE=1, preload by running 65535 instructions, then 3 more -> all_time=16'hFFFF, ovf=1. Repeat with SATURATE=0 -> all_time=2, ovf=1.
- Reset mid-operation: reset=1 while counts are nonzero and state is HALTED -> next cycle all counts 0, halted=0, ovf=0, and counting resumes on the next ce edge.
- ce gating: alternate ce=1/0 over 20 edges with is_jump=1 throughout -> all_time=10, j_change=10.

Source files
------------

// File: rtl/exec_stat_counter.sv
// Execution statistics for the single-cycle MIPS CPU: cycle, jump,
// branch and taken-branch counters; frozen while halted on syscall.
//
// Ports:
//   clk, reset        clock, synchronous active-high reset
//   ce                one instruction retires on each edge with ce=1
//   halt, go          syscall halt decode / resume request
//   is_jump           current instruction is j/jal/jr
//   is_branch         current instruction is a conditional branch
//   branch_taken      branch condition true (ignored without is_branch)
//   all_time          executed-instruction count
//   j_change          unconditional jump count
//   b_change          conditional branch count
//   b_change_success  taken conditional branch count
//   halted            1 while in HALTED
//   ovf               sticky: increment requested at all-ones
module exec_stat_counter #(
  parameter int unsigned CNT_W    = 16,
  parameter bit          SATURATE = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             ce,
  input  logic             halt,
  input  logic             go,
  input  logic             is_jump,
  input  logic             is_branch,
  input  logic             branch_taken,
  output logic [CNT_W-1:0] all_time,
  output logic [CNT_W-1:0] j_change,
  output logic [CNT_W-1:0] b_change,
  output logic [CNT_W-1:0] b_change_success,
  output logic             halted,
  output logic             ovf
);

  typedef enum logic {
    RUN    = 1'b0,
    HALTED = 1'b1
  } state_t;

  state_t state_q;
  state_t state_d;

  // Index 0: all_time, 1: jump, 2: branch, 3: taken branch.
  logic [3:0][CNT_W-1:0] cnt_q;
  logic [3:0][CNT_W-1:0] cnt_d;
  logic [3:0]            inc;
  logic [3:0]            at_max;
  logic                  ovf_q;
  logic                  ovf_d;
  logic                  count_en;

  assign count_en = (state_q == RUN) && ce;

  assign inc[0] = count_en;
  assign inc[1] = count_en && is_jump;
  assign inc[2] = count_en && is_branch;
  assign inc[3] = count_en && is_branch && branch_taken;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      RUN: begin
        if (ce && halt) begin
          state_d = HALTED;
        end
      end
      HALTED: begin
        if (go) begin
          state_d = RUN;
        end
      end
      default: state_d = RUN;
    endcase
  end

  always_comb begin
    cnt_d  = cnt_q;
    at_max = '0;
    for (int i = 0; i < 4; i++) begin
      at_max[i] = &cnt_q[i];
      if (inc[i]) begin
        if (!at_max[i]) begin
          cnt_d[i] = cnt_q[i] + CNT_W'(1);
        end else if (!SATURATE) begin
          cnt_d[i] = '0;
        end
      end
    end
    ovf_d = ovf_q || (|(inc & at_max));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= RUN;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
    end
  end

  assign all_time         = cnt_q[0];
  assign j_change         = cnt_q[1];
  assign b_change         = cnt_q[2];
  assign b_change_success = cnt_q[3];
  assign halted           = (state_q == HALTED);
  assign ovf              = ovf_q;

endmodule
